matrix_slot_allocator: RTL
==========================

// Module: matrix_slot_allocator
// PURPOSE
// - Parametrised matrix directory and allocator for the matrix calculator; tracks per-slot dims and BRAM start addresses.
// - Generalises slot count, address width and dimension width; adds explicit free and a per-dimension storage cap.
// - Replaces single-cycle combinational search with a sequential scan FSM, one slot per cycle; sits between input/gen controllers and BRAM.
// PARAMETERS
// NUM_SLOTS     20    directory entries (>=2); SLOT_W = $clog2(NUM_SLOTS)
// ADDR_W        12    BRAM element-address width
// MAX_ELEMENTS  4096  BRAM capacity in elements (<= 2**ADDR_W)
// DIM_W         5     row/col field width
// MAX_DIM       5     largest legal m or n
// AGE_W         8     commit-order stamp width
// PORTS
// clk           in   1          system clock, rising edge
// rst           in   1          asynchronous, active-high reset
// dim_limit     in   SLOT_W+1   max matrices per (m,n); 0 = unlimited
// alloc_req     in   1          start allocation; sampled only when alloc_busy=0
// alloc_m/n     in   DIM_W      requested dims, captured on accept
// alloc_busy    out  1          scan in progress
// alloc_done    out  1          1-cycle pulse, result valid
// alloc_ok      out  1          allocation succeeded
// alloc_replace out  1          slot granted by replacing existing matrix
// alloc_slot    out  SLOT_W     granted slot
// alloc_addr    out  ADDR_W     granted start address
// commit_req    in   1          write directory entry
// commit_slot   in   SLOT_W     entry to write
// commit_m/n    in   DIM_W      dims to store
// commit_addr   in   ADDR_W     start address to store
// free_req      in   1          invalidate entry
// free_slot     in   SLOT_W     entry to invalidate
// query_slot    in   SLOT_W     combinational lookup index
// query_valid   out  1          entry valid
// query_m/n     out  DIM_W      stored dims
// query_addr    out  ADDR_W     stored start address
// query_count   out  ADDR_W+1   m*n of entry
// total_count   out  SLOT_W+1   number of valid entries (registered)
// BEHAVIOUR
// - Reset: all entries invalid, fields 0, age counter 0; alloc_busy/done/ok/replace=0, alloc_slot=0, alloc_addr=0, total_count=0; FSM->IDLE.
// - FSM IDLE: alloc_req=1 -> capture m,n,dim_limit; clear accumulators; idx=0; ->SCAN.
// - FSM SCAN: one slot/cycle: first invalid slot; max end addr of valid slots; count of valid same-dim slots;
//   same-dim slot with oldest age (age = stamp_now - stamp_slot, mod 2**AGE_W). idx==NUM_SLOTS-1 -> DECIDE.
// - FSM DECIDE: evaluate rules below, register outputs -> DONE. DONE: alloc_done=1 one cycle -> IDLE.
// - Latency: alloc_req accept to alloc_done = NUM_SLOTS+2 cycles; alloc_busy high from cycle after accept until DONE inclusive.
// - Decide rules in order: m or n ==0 or >MAX_DIM -> fail;
//   dim_limit!=0 && same_count>=dim_limit -> cap rule (CONFIGURATION);
//   no invalid slot -> fail; max_end + m*n > MAX_ELEMENTS -> fail; else ok, slot=first invalid, addr=max_end.
// - Product m*n zero-extended to ADDR_W+1 bits before add; compare in ADDR_W+1 bits (no wrap).
// - On fail: alloc_ok=0, alloc_slot=0, alloc_addr=0, alloc_replace=0.
// - Allocation does not mark slot valid; only commit does. Commit: entry valid, fields written, stamp=age counter, counter+1 (wraps).
// - free_req: entry invalid; freeing invalid slot is a no-op. Slot index >= NUM_SLOTS ignored for commit/free/query (query returns zeros).
// - commit_req and free_req same slot same cycle: commit wins. Different slots: both apply.
// - total_count updated the cycle after commit of invalid slot (+1) or free of valid slot (-1); net 0 if both.
// - commit/free accepted while alloc_busy=1: scan restarts at idx=0 next cycle (latency extends); alloc_req during busy ignored.
// - rst mid-scan: immediate abort to reset state, no alloc_done.
// CONFIGURATION
// - MATRIX_ALLOC_REPLACE_EN defined: cap reached -> alloc_ok=1, alloc_replace=1, slot=oldest same-dim slot, addr=its start address.
// - MATRIX_ALLOC_REPLACE_EN undefined: cap reached -> fail (alloc_ok=0); alloc_replace tied 0.
// TESTING
// - Reset, alloc 2x3 on empty -> done after NUM_SLOTS+2 cycles, ok=1, slot=0, addr=0, replace=0.
// - Commit slot0 2x3@0, alloc 3x3 -> slot=1, addr=6; commit, free slot0 -> total_count 2->1, query0 valid=0.
// - dim_limit=2, commit 2x2 in slots 0,1 (slot0 older), alloc 2x2 -> REPLACE_EN: ok=1, replace=1, slot=0; else ok=0.
// - Alloc 0x3 and 6x1 -> ok=0; fill MAX_ELEMENTS-4 elements, alloc 2x3 -> ok=0; alloc 2x2 -> ok=1.
// - Commit slot5 during SCAN -> done delayed, result reflects slot5; commit+free slot5 same cycle -> slot5 valid.
// - Assert rst mid-SCAN -> busy=0, no done pulse, total_count=0.

Source files
------------

// File: rtl/matrix_slot_allocator.sv
// matrix_slot_allocator: matrix directory (valid flag, dims, BRAM start address and
// commit-order stamp per slot) plus an allocator that walks the directory one slot per
// cycle (IDLE -> SCAN -> DECIDE -> DONE) and grants a free slot/start address.
// Optional feature: define MATRIX_ALLOC_REPLACE_EN so that reaching the per-dimension
// cap grants the oldest same-dimension slot for replacement instead of failing.
module matrix_slot_allocator #(
    parameter int NUM_SLOTS    = 20,
    parameter int ADDR_W       = 12,
    parameter int MAX_ELEMENTS = 4096,
    parameter int DIM_W        = 5,
    parameter int MAX_DIM      = 5,
    parameter int AGE_W        = 8,
    localparam int SLOT_W      = $clog2(NUM_SLOTS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SLOT_W:0]   dim_limit,
    input  logic              alloc_req,
    input  logic [DIM_W-1:0]  alloc_m,
    input  logic [DIM_W-1:0]  alloc_n,
    output logic              alloc_busy,
    output logic              alloc_done,
    output logic              alloc_ok,
    output logic              alloc_replace,
    output logic [SLOT_W-1:0] alloc_slot,
    output logic [ADDR_W-1:0] alloc_addr,
    input  logic              commit_req,
    input  logic [SLOT_W-1:0] commit_slot,
    input  logic [DIM_W-1:0]  commit_m,
    input  logic [DIM_W-1:0]  commit_n,
    input  logic [ADDR_W-1:0] commit_addr,
    input  logic              free_req,
    input  logic [SLOT_W-1:0] free_slot,
    input  logic [SLOT_W-1:0] query_slot,
    output logic              query_valid,
    output logic [DIM_W-1:0]  query_m,
    output logic [DIM_W-1:0]  query_n,
    output logic [ADDR_W-1:0] query_addr,
    output logic [ADDR_W:0]   query_count,
    output logic [SLOT_W:0]   total_count
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SCAN   = 2'd1;
    localparam logic [1:0] ST_DECIDE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [SLOT_W-1:0] LAST_IDX = SLOT_W'(NUM_SLOTS - 1);
    localparam logic [ADDR_W:0]   CAPACITY = (ADDR_W+1)'(MAX_ELEMENTS);
    localparam logic [DIM_W-1:0]  DIM_MAX  = DIM_W'(MAX_DIM);

    // Directory storage
    logic [NUM_SLOTS-1:0] valid_q;
    logic [DIM_W-1:0]     dir_m_q     [NUM_SLOTS];
    logic [DIM_W-1:0]     dir_n_q     [NUM_SLOTS];
    logic [ADDR_W-1:0]    dir_addr_q  [NUM_SLOTS];
    logic [AGE_W-1:0]     dir_stamp_q [NUM_SLOTS];
    logic [AGE_W-1:0]     age_cnt_q;
    logic [SLOT_W:0]      total_q, total_d;

    // Allocator state
    logic [1:0]        state_q, state_d;
    logic [SLOT_W-1:0] idx_q, idx_d;
    logic [DIM_W-1:0]  req_m_q, req_m_d, req_n_q, req_n_d;
    logic [SLOT_W:0]   lim_q, lim_d;
    logic              free_found_q, free_found_d;
    logic [SLOT_W-1:0] first_free_q, first_free_d;
    logic [ADDR_W:0]   max_end_q, max_end_d;
    logic [SLOT_W:0]   same_cnt_q, same_cnt_d;
    logic              old_found_q, old_found_d;
    logic [SLOT_W-1:0] old_slot_q, old_slot_d;
    logic [AGE_W-1:0]  old_age_q, old_age_d;
    logic              ok_q, ok_d, rep_q, rep_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic [NUM_SLOTS-1:0] commit_hit, free_hit;
    logic accept, restart, scan_step;
    logic cur_valid, cur_same;
    logic [ADDR_W:0]  cur_end, prod_req, need_end;
    logic [AGE_W-1:0] cur_age;
    logic dims_bad, cap_hit, query_in;

    // Per-slot write decode; a free aimed at the slot being committed loses to the commit.
    // Out-of-range indices match no slot and are therefore ignored.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi = gi + 1) begin : g_slot_dec
            assign commit_hit[gi] = commit_req && (commit_slot == SLOT_W'(gi));
            assign free_hit[gi]   = free_req && (free_slot == SLOT_W'(gi)) && !commit_hit[gi];
        end
    endgenerate

    // Directory update: commit writes fields and stamps commit order, free clears valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= '0;
            age_cnt_q <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                dir_m_q[i]     <= '0;
                dir_n_q[i]     <= '0;
                dir_addr_q[i]  <= '0;
                dir_stamp_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (commit_hit[i]) begin
                    valid_q[i]     <= 1'b1;
                    dir_m_q[i]     <= commit_m;
                    dir_n_q[i]     <= commit_n;
                    dir_addr_q[i]  <= commit_addr;
                    dir_stamp_q[i] <= age_cnt_q;
                end else if (free_hit[i]) begin
                    valid_q[i] <= 1'b0;
                end
            end
            if (|commit_hit) begin
                age_cnt_q <= age_cnt_q + AGE_W'(1);
            end
        end
    end

    // Valid-entry count: +1 for committing an empty slot, -1 for freeing a live one
    always_comb begin
        total_d = total_q;
        if (|(commit_hit & ~valid_q)) total_d = total_d + (SLOT_W+1)'(1);
        if (|(free_hit & valid_q))    total_d = total_d - (SLOT_W+1)'(1);
    end

    // Any directory change during SCAN/DECIDE invalidates the partial scan.
    assign accept    = (state_q == ST_IDLE) && alloc_req;
    assign restart   = ((state_q == ST_SCAN) || (state_q == ST_DECIDE)) && ((|commit_hit) || (|free_hit));
    assign scan_step = (state_q == ST_SCAN) && !restart;

    assign cur_valid = valid_q[idx_q];
    assign cur_same  = cur_valid && (dir_m_q[idx_q] == req_m_q) && (dir_n_q[idx_q] == req_n_q);
    assign cur_end   = {1'b0, dir_addr_q[idx_q]} + (ADDR_W+1)'(dir_m_q[idx_q]) * (ADDR_W+1)'(dir_n_q[idx_q]);
    assign cur_age   = age_cnt_q - dir_stamp_q[idx_q];

    // Scan accumulators: first free slot, highest end address, same-dim count and oldest
    always_comb begin
        free_found_d = free_found_q;
        first_free_d = first_free_q;
        max_end_d    = max_end_q;
        same_cnt_d   = same_cnt_q;
        old_found_d  = old_found_q;
        old_slot_d   = old_slot_q;
        old_age_d    = old_age_q;
        if (accept || restart) begin
            free_found_d = 1'b0;
            first_free_d = '0;
            max_end_d    = '0;
            same_cnt_d   = '0;
            old_found_d  = 1'b0;
            old_slot_d   = '0;
            old_age_d    = '0;
        end else if (scan_step) begin
            if (!cur_valid && !free_found_q) begin
                free_found_d = 1'b1;
                first_free_d = idx_q;
            end
            if (cur_valid && (cur_end > max_end_q)) begin
                max_end_d = cur_end;
            end
            if (cur_same) begin
                same_cnt_d = same_cnt_q + (SLOT_W+1)'(1);
                // Strict compare keeps the lowest index on equal ages
                if (!old_found_q || (cur_age > old_age_q)) begin
                    old_found_d = 1'b1;
                    old_slot_d  = idx_q;
                    old_age_d   = cur_age;
                end
            end
        end
    end

    assign prod_req = (ADDR_W+1)'(req_m_q) * (ADDR_W+1)'(req_n_q);
    assign need_end = max_end_q + prod_req;
    assign dims_bad = (req_m_q == '0) || (req_n_q == '0) || (req_m_q > DIM_MAX) || (req_n_q > DIM_MAX);
    assign cap_hit  = (lim_q != '0) && (same_cnt_q >= lim_q);

`ifndef MATRIX_ALLOC_REPLACE_EN
    // Oldest-slot index only feeds the replacement grant
    logic unused_oldest;
    assign unused_oldest = ^old_slot_q;
`endif

    // Allocator FSM: request capture, slot walk, rule evaluation, done pulse
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        req_m_d = req_m_q;
        req_n_d = req_n_q;
        lim_d   = lim_q;
        ok_d    = ok_q;
        rep_d   = rep_q;
        slot_d  = slot_q;
        addr_d  = addr_q;
        if (restart) begin
            idx_d   = '0;
            state_d = ST_SCAN;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (alloc_req) begin
                        req_m_d = alloc_m;
                        req_n_d = alloc_n;
                        lim_d   = dim_limit;
                        idx_d   = '0;
                        state_d = ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (idx_q == LAST_IDX) state_d = ST_DECIDE;
                    else                   idx_d   = idx_q + SLOT_W'(1);
                end
                ST_DECIDE: begin
                    ok_d    = 1'b0;
                    rep_d   = 1'b0;
                    slot_d  = '0;
                    addr_d  = '0;
                    state_d = ST_DONE;
                    if (dims_bad) begin
                        ok_d = 1'b0;
                    end else if (cap_hit) begin
`ifdef MATRIX_ALLOC_REPLACE_EN
                        ok_d   = 1'b1;
                        rep_d  = 1'b1;
                        slot_d = old_slot_q;
                        addr_d = dir_addr_q[old_slot_q];
`else
                        ok_d = 1'b0;
`endif
                    end else if (free_found_q && (need_end <= CAPACITY)) begin
                        ok_d   = 1'b1;
                        slot_d = first_free_q;
                        addr_d = max_end_q[ADDR_W-1:0];
                    end
                end
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Allocator and count registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            req_m_q      <= '0;
            req_n_q      <= '0;
            lim_q        <= '0;
            free_found_q <= 1'b0;
            first_free_q <= '0;
            max_end_q    <= '0;
            same_cnt_q   <= '0;
            old_found_q  <= 1'b0;
            old_slot_q   <= '0;
            old_age_q    <= '0;
            ok_q         <= 1'b0;
            rep_q        <= 1'b0;
            slot_q       <= '0;
            addr_q       <= '0;
            total_q      <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            req_m_q      <= req_m_d;
            req_n_q      <= req_n_d;
            lim_q        <= lim_d;
            free_found_q <= free_found_d;
            first_free_q <= first_free_d;
            max_end_q    <= max_end_d;
            same_cnt_q   <= same_cnt_d;
            old_found_q  <= old_found_d;
            old_slot_q   <= old_slot_d;
            old_age_q    <= old_age_d;
            ok_q         <= ok_d;
            rep_q        <= rep_d;
            slot_q       <= slot_d;
            addr_q       <= addr_d;
            total_q      <= total_d;
        end
    end

    assign alloc_busy    = (state_q != ST_IDLE);
    assign alloc_done    = (state_q == ST_DONE);
    assign alloc_ok      = ok_q;
    assign alloc_replace = rep_q;
    assign alloc_slot    = slot_q;
    assign alloc_addr    = addr_q;
    assign total_count   = total_q;

    // Combinational lookup; out-of-range indices read as an empty entry
    assign query_in    = ({1'b0, query_slot} < (SLOT_W+1)'(NUM_SLOTS));
    assign query_valid = query_in && valid_q[query_slot];
    assign query_m     = query_in ? dir_m_q[query_slot] : '0;
    assign query_n     = query_in ? dir_n_q[query_slot] : '0;
    assign query_addr  = query_in ? dir_addr_q[query_slot] : '0;
    assign query_count = query_in ? (ADDR_W+1)'(dir_m_q[query_slot]) * (ADDR_W+1)'(dir_n_q[query_slot]) : '0;
endmodule
